// File: rtl/oddeven_pkg.sv
// Shared types and constants for the odd/even sequence checker.
// Optional sticky error capture is enabled with ODDEVEN_STICKY_ERR_EN.
package oddeven_pkg;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned Step         = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StLocked
  } state_e;

endpackage

// File: rtl/oddeven_step_cmp.sv
// Combinational step/parity comparator. Shared by the FSM and the sticky capture path.
module oddeven_step_cmp
  import oddeven_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  input  logic             mode,
  output logic             step_ok,
  output logic             parity_ok,
  output logic [WIDTH-1:0] expected
);

  // Modular add makes the 0xFFFE->0x0000 and 0xFFFF->0x0001 wraps legal steps.
  assign expected  = prev + WIDTH'(Step);
  assign step_ok   = (count_in == expected);
  assign parity_ok = (count_in[0] == mode);

endmodule

// File: rtl/oddeven_seq_checker.sv
// Monitors an odd/even counter stream for +2 steps with the right parity.
// Define ODDEVEN_STICKY_ERR_EN to add first-error capture outputs.
module oddeven_seq_checker
  import oddeven_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] last_good
`ifdef ODDEVEN_STICKY_ERR_EN
  ,
  output logic             sticky_err,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual
`endif
);

  localparam int unsigned RunW = 4;
  localparam logic [RunW-1:0] LockRun = RunW'(LOCK_LEN);

  state_e           state_q, state_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] last_good_q, last_good_d;
  logic             mode_q, mode_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             step_ok, parity_ok, mode_chg;
  logic [WIDTH-1:0] expected;
  logic             lock_err;

  oddeven_step_cmp #(
    .WIDTH(WIDTH)
  ) u_step_cmp (
    .prev     (prev_q),
    .count_in (count_in),
    .mode     (mode),
    .step_ok  (step_ok),
    .parity_ok(parity_ok),
    .expected (expected)
  );

  assign mode_chg = (mode != mode_q);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    prev_d      = prev_q;
    last_good_d = last_good_q;
    mode_d      = mode_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    lock_err    = 1'b0;

    if (in_valid) begin
      mode_d = mode;
      unique case (state_q)
        StIdle: begin
          if (parity_ok) begin
            prev_d      = count_in;
            last_good_d = count_in;
            run_d       = RunW'(1);
            state_d     = StSync;
          end
        end
        StSync: begin
          if (!parity_ok) begin
            run_d   = '0;
            state_d = StIdle;
          end else if (step_ok && !mode_chg) begin
            prev_d      = count_in;
            last_good_d = count_in;
            run_d       = run_q + RunW'(1);
            if (run_d == LockRun) state_d = StLocked;
          end else begin
            // Restart the run from this sample.
            prev_d      = count_in;
            last_good_d = count_in;
            run_d       = RunW'(1);
          end
        end
        StLocked: begin
          if (mode_chg || !step_ok || !parity_ok) begin
            if (!mode_chg) begin
              lock_err    = 1'b1;
              err_pulse_d = 1'b1;
              if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
            end
            if (parity_ok) begin
              prev_d  = count_in;
              run_d   = RunW'(1);
              state_d = StSync;
              if (mode_chg) last_good_d = count_in;
            end else begin
              run_d   = '0;
              state_d = StIdle;
            end
          end else begin
            prev_d      = count_in;
            last_good_d = count_in;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      run_q       <= '0;
      prev_q      <= '0;
      last_good_q <= '0;
      mode_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      prev_q      <= prev_d;
      last_good_q <= last_good_d;
      mode_q      <= mode_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign last_good = last_good_q;

`ifdef ODDEVEN_STICKY_ERR_EN
  logic             sticky_q;
  logic [WIDTH-1:0] err_expected_q, err_actual_q;

  // Only the first locked error is recorded; later ones leave the capture intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q       <= 1'b0;
      err_expected_q <= '0;
      err_actual_q   <= '0;
    end else if (lock_err && !sticky_q) begin
      sticky_q       <= 1'b1;
      err_expected_q <= expected;
      err_actual_q   <= count_in;
    end
  end

  assign sticky_err   = sticky_q;
  assign err_expected = err_expected_q;
  assign err_actual   = err_actual_q;
`else
  logic unused_lock_err;
  logic [WIDTH-1:0] unused_expected;
  assign unused_lock_err = lock_err;
  assign unused_expected = expected;
`endif

endmodule

// File: tb/tb_oddeven_seq_checker.sv
// Directed, table-driven bench for oddeven_seq_checker plus saturation and reset sequences.
module tb_oddeven_seq_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic        in_valid;
  logic [15:0] count_in;
  logic        locked;
  logic        err_pulse;
  logic [7:0]  err_count;
  logic [15:0] last_good;
`ifdef ODDEVEN_STICKY_ERR_EN
  logic        sticky_err;
  logic [15:0] err_expected;
  logic [15:0] err_actual;
`endif

  always #5 clk = ~clk;

  oddeven_seq_checker dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .in_valid (in_valid),
    .count_in (count_in),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .last_good(last_good)
`ifdef ODDEVEN_STICKY_ERR_EN
    ,
    .sticky_err  (sticky_err),
    .err_expected(err_expected),
    .err_actual  (err_actual)
`endif
  );

  typedef struct {
    logic        rst;
    logic        md;
    logic        vld;
    logic [15:0] cnt;
    logic        exp_locked;
    logic        exp_pulse;
    logic [7:0]  exp_count;
    logic [15:0] exp_last;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void add(logic rst, logic md, logic vld, logic [15:0] cnt, logic lk,
                              logic ep, logic [7:0] ec, logic [15:0] lg);
    vec_t v;
    v.rst = rst; v.md = md; v.vld = vld; v.cnt = cnt;
    v.exp_locked = lk; v.exp_pulse = ep; v.exp_count = ec; v.exp_last = lg;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  // Drive one cycle, then sample just after the edge.
  task automatic cyc(logic rst, logic md, logic vld, logic [15:0] cnt);
    reset = rst; mode = md; in_valid = vld; count_in = cnt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; in_valid = 1'b0; count_in = '0;

    //  rst md vld cnt      lk ep ec  last
    add(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000);  // reset state
    add(0, 1, 1, 16'd1,    0, 0, 0, 16'd1);
    add(0, 1, 1, 16'd3,    0, 0, 0, 16'd3);
    add(0, 1, 1, 16'd5,    0, 0, 0, 16'd5);
    add(0, 1, 1, 16'd7,    1, 0, 0, 16'd7);     // fourth good sample locks
    add(0, 1, 0, 16'd99,   1, 0, 0, 16'd7);     // invalid: hold
    add(0, 1, 1, 16'd9,    1, 0, 0, 16'd9);
    add(0, 1, 1, 16'd12,   0, 1, 1, 16'd9);     // bad step+parity -> IDLE
    add(0, 1, 0, 16'd0,    0, 0, 1, 16'd9);     // pulse is one cycle
    add(0, 0, 1, 16'hFFFC, 0, 0, 1, 16'hFFFC);
    add(0, 0, 1, 16'hFFFE, 0, 0, 1, 16'hFFFE);
    add(0, 0, 1, 16'h0000, 0, 0, 1, 16'h0000);  // wrap is legal
    add(0, 0, 1, 16'h0002, 1, 0, 1, 16'h0002);
    add(0, 1, 1, 16'd3,    0, 0, 1, 16'd3);     // mode change is not an error
    add(0, 1, 1, 16'd5,    0, 0, 1, 16'd5);
    add(0, 1, 1, 16'd7,    0, 0, 1, 16'd7);
    add(0, 1, 1, 16'd9,    1, 0, 1, 16'd9);
    add(0, 0, 1, 16'd0,    0, 0, 1, 16'd0);     // mode 1->0 while locked
    add(0, 0, 1, 16'd2,    0, 0, 1, 16'd2);
    add(0, 0, 1, 16'd4,    0, 0, 1, 16'd4);
    add(0, 0, 1, 16'd6,    1, 0, 1, 16'd6);
    add(0, 0, 1, 16'd7,    0, 1, 2, 16'd6);     // bad parity while locked

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rst, vq[i].md, vq[i].vld, vq[i].cnt);
      chk($sformatf("v%0d.locked", i), 32'(locked), 32'(vq[i].exp_locked));
      chk($sformatf("v%0d.err_pulse", i), 32'(err_pulse), 32'(vq[i].exp_pulse));
      chk($sformatf("v%0d.err_count", i), 32'(err_count), 32'(vq[i].exp_count));
      chk($sformatf("v%0d.last_good", i), 32'(last_good), 32'(vq[i].exp_last));
    end

`ifdef ODDEVEN_STICKY_ERR_EN
    chk("sticky_err", 32'(sticky_err), 32'd1);
    chk("err_expected", 32'(err_expected), 32'd11);
    chk("err_actual", 32'(err_actual), 32'd12);
`endif

    // Saturation: lock then bad parity, repeated; count starts at 2.
    for (int i = 0; i < 300; i++) begin
      logic [15:0] base;
      int          exp_ec;
      base = 16'(i * 16);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, base + 16'(2 * k));
      if (i % 50 == 0) chk($sformatf("sat%0d.locked", i), 32'(locked), 32'd1);
      cyc(1'b0, 1'b0, 1'b1, base + 16'd9);
      exp_ec = (i + 3 > 255) ? 255 : i + 3;
      chk($sformatf("sat%0d.err_pulse", i), 32'(err_pulse), 32'd1);
      chk($sformatf("sat%0d.err_count", i), 32'(err_count), 32'(exp_ec));
    end

`ifdef ODDEVEN_STICKY_ERR_EN
    chk("sticky_hold_expected", 32'(err_expected), 32'd11);
    chk("sticky_hold_actual", 32'(err_actual), 32'd12);
`endif

    // Reset while locked with err_count=5.
    cyc(1'b1, 1'b0, 1'b0, 16'd0);
    chk("rst0.err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 16'(100 + 2 * k));
      cyc(1'b0, 1'b0, 1'b1, 16'd107);
    end
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 16'(200 + 2 * k));
    chk("pre_rst.locked", 32'(locked), 32'd1);
    chk("pre_rst.err_count", 32'(err_count), 32'd5);
    chk("pre_rst.last_good", 32'(last_good), 32'd206);

    cyc(1'b1, 1'b1, 1'b1, 16'd208);  // sample during reset ignored
    chk("rst.locked", 32'(locked), 32'd0);
    chk("rst.err_pulse", 32'(err_pulse), 32'd0);
    chk("rst.err_count", 32'(err_count), 32'd0);
    chk("rst.last_good", 32'(last_good), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 16'd210);
    chk("rst_hold.last_good", 32'(last_good), 32'd0);
`ifdef ODDEVEN_STICKY_ERR_EN
    chk("rst.sticky_err", 32'(sticky_err), 32'd0);
    chk("rst.err_expected", 32'(err_expected), 32'd0);
`endif

    // After reset: mode_q is 0 and state IDLE, so an odd sample in mode 1 starts a run.
    cyc(1'b0, 1'b1, 1'b1, 16'd21);
    chk("post_rst.last_good", 32'(last_good), 32'd21);
    chk("post_rst.locked", 32'(locked), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
